// File: rtl/ppi_bus_sequencer.sv
// ppi_bus_sequencer
//   Shares one 8255-style PPI between two requesters. Grants are round-robin; each granted
//   access runs as a timed bus cycle SETUP -> STROBE -> HOLD -> DONE, then the sequencer returns
//   to IDLE, so the bus is released for at least one cycle between accesses.
//
//   Optional feature (macro PPI_SEQ_INIT_EN): after reset release an INIT write cycle stores
//   INIT_CW at PPI address 2'b11 before any requester is served; it issues no ACK.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), asynchronous active-low reset
//   req*_i, rw*_i              request (held until ack), 1 = read / 0 = write
//   addr*_i, wdata*_i          PPI register address and write data, stable while req is high
//   ack*_o                     one-cycle completion pulse
//   rdata_o                    last read data, updated on the edge ending the last strobe cycle
//   busy_o                     high in every state except IDLE
//   ppi_cs_n_o/rd_n_o/wr_n_o   PPI chip select and strobes, active low
//   ppi_a_o, ppi_dout_o        PPI address and write data
//   ppi_doe_o                  data bus output enable, write cycles only
//   ppi_din_i                  PPI read data
module ppi_bus_sequencer #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1
`ifdef PPI_SEQ_INIT_EN
    , parameter logic [7:0] INIT_CW   = 8'h80
`endif
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       rw0_i,
    input  logic       rw1_i,
    input  logic [1:0] addr0_i,
    input  logic [1:0] addr1_i,
    input  logic [7:0] wdata0_i,
    input  logic [7:0] wdata1_i,
    output logic       ack0_o,
    output logic       ack1_o,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       ppi_cs_n_o,
    output logic       ppi_rd_n_o,
    output logic       ppi_wr_n_o,
    output logic [1:0] ppi_a_o,
    output logic [7:0] ppi_dout_o,
    output logic       ppi_doe_o,
    input  logic [7:0] ppi_din_i
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StDone
`ifdef PPI_SEQ_INIT_EN
        , StInit
`endif
    } state_e;

    // Phase counters are loaded with N-1 on entry and the phase ends when they reach zero.
    localparam logic [3:0] SetupLd  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] StrobeLd = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HoldLd   = 4'(HOLD_CYC - 1);

    state_e     state_q;
    logic [3:0] cnt_q;
    logic       rr_last_q;
    logic       who_q;
    logic       is_rd_q;
`ifdef PPI_SEQ_INIT_EN
    logic       init_q;
`endif

    logic       grant_any;
    logic       grant_sel;
    logic       sel_rw;
    logic [1:0] sel_addr;
    logic [7:0] sel_wdata;

    // On a tie the requester that was not served last wins.
    assign grant_any = req0_i | req1_i;
    assign grant_sel = (req0_i & req1_i) ? ~rr_last_q : req1_i;
    assign sel_rw    = grant_sel ? rw1_i    : rw0_i;
    assign sel_addr  = grant_sel ? addr1_i  : addr0_i;
    assign sel_wdata = grant_sel ? wdata1_i : wdata0_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= 4'd0;
            rr_last_q  <= 1'b1;
            who_q      <= 1'b0;
            is_rd_q    <= 1'b0;
            ack0_o     <= 1'b0;
            ack1_o     <= 1'b0;
            rdata_o    <= 8'h00;
            ppi_cs_n_o <= 1'b1;
            ppi_rd_n_o <= 1'b1;
            ppi_wr_n_o <= 1'b1;
            ppi_a_o    <= 2'b00;
            ppi_dout_o <= 8'h00;
            ppi_doe_o  <= 1'b0;
`ifdef PPI_SEQ_INIT_EN
            init_q     <= 1'b0;
            state_q    <= StInit;
            busy_o     <= 1'b1;
`else
            state_q    <= StIdle;
            busy_o     <= 1'b0;
`endif
        end else begin
            ack0_o <= 1'b0;
            ack1_o <= 1'b0;
            unique case (state_q)
`ifdef PPI_SEQ_INIT_EN
                StInit: begin
                    init_q     <= 1'b1;
                    is_rd_q    <= 1'b0;
                    ppi_cs_n_o <= 1'b0;
                    ppi_a_o    <= 2'b11;
                    ppi_dout_o <= INIT_CW;
                    ppi_doe_o  <= 1'b1;
                    cnt_q      <= SetupLd;
                    state_q    <= StSetup;
                end
`endif
                StIdle: begin
                    if (grant_any) begin
`ifdef PPI_SEQ_INIT_EN
                        init_q     <= 1'b0;
`endif
                        busy_o     <= 1'b1;
                        who_q      <= grant_sel;
                        rr_last_q  <= grant_sel;
                        is_rd_q    <= sel_rw;
                        ppi_cs_n_o <= 1'b0;
                        ppi_a_o    <= sel_addr;
                        ppi_doe_o  <= ~sel_rw;
                        if (!sel_rw) begin
                            ppi_dout_o <= sel_wdata;
                        end
                        cnt_q      <= SetupLd;
                        state_q    <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt_q == 4'd0) begin
                        ppi_rd_n_o <= ~is_rd_q;
                        ppi_wr_n_o <= is_rd_q;
                        cnt_q      <= StrobeLd;
                        state_q    <= StStrobe;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StStrobe: begin
                    if (cnt_q == 4'd0) begin
                        if (is_rd_q) begin
                            rdata_o <= ppi_din_i;
                        end
                        ppi_rd_n_o <= 1'b1;
                        ppi_wr_n_o <= 1'b1;
                        cnt_q      <= HoldLd;
                        state_q    <= StHold;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StHold: begin
                    if (cnt_q == 4'd0) begin
                        ppi_cs_n_o <= 1'b1;
                        ppi_doe_o  <= 1'b0;
`ifdef PPI_SEQ_INIT_EN
                        ack0_o     <= ~init_q & ~who_q;
                        ack1_o     <= ~init_q & who_q;
`else
                        ack0_o     <= ~who_q;
                        ack1_o     <= who_q;
`endif
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Bench for ppi_bus_sequencer: two instances (default timing and 2/4/3 timing) share one clock,
// reset and PPI read bus. A per-instance reference model tracks each access as "cycle number
// since grant" and derives every expected pin value from the phase lengths.
`timescale 1ns/1ps
module tb_ppi_bus_sequencer;

`ifdef PPI_SEQ_INIT_EN
    localparam bit INIT_ON = 1'b1;
`else
    localparam bit INIT_ON = 1'b0;
`endif

    typedef enum int {MIdle, MHold, MRand} mode_e;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       req   [2][2];
    logic       rw    [2][2];
    logic [1:0] addr  [2][2];
    logic [7:0] wdata [2][2];
    logic [7:0] din;
    logic       ack   [2][2];
    logic [7:0] rdata [2];
    logic       busy  [2];
    logic       cs_n  [2];
    logic       rd_n  [2];
    logic       wr_n  [2];
    logic       doe   [2];
    logic [1:0] pa    [2];
    logic [7:0] dout  [2];

    mode_e mode = MIdle;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_cfg
        localparam int S = (k == 0) ? 1 : 2;
        localparam int T = (k == 0) ? 3 : 4;
        localparam int H = (k == 0) ? 1 : 3;
        localparam int L = S + T + H + 1;

        ppi_bus_sequencer #(
            .SETUP_CYC (S),
            .STROBE_CYC(T),
            .HOLD_CYC  (H)
        ) u_dut (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .req0_i    (req[k][0]),
            .req1_i    (req[k][1]),
            .rw0_i     (rw[k][0]),
            .rw1_i     (rw[k][1]),
            .addr0_i   (addr[k][0]),
            .addr1_i   (addr[k][1]),
            .wdata0_i  (wdata[k][0]),
            .wdata1_i  (wdata[k][1]),
            .ack0_o    (ack[k][0]),
            .ack1_o    (ack[k][1]),
            .rdata_o   (rdata[k]),
            .busy_o    (busy[k]),
            .ppi_cs_n_o(cs_n[k]),
            .ppi_rd_n_o(rd_n[k]),
            .ppi_wr_n_o(wr_n[k]),
            .ppi_a_o   (pa[k]),
            .ppi_dout_o(dout[k]),
            .ppi_doe_o (doe[k]),
            .ppi_din_i (din)
        );

        // Reference model: c = cycle number since the grant edge (1..L), act = access in flight.
        bit         act = 1'b0, m_rd = 1'b0, m_who = 1'b0, m_rr = 1'b1, m_init = 1'b0;
        bit         m_pend = INIT_ON;
        int         c = 0;
        logic [1:0] m_a = 2'b00;
        logic [7:0] m_wd = 8'h00, m_rdata = 8'h00;
        logic       w;
        assign w = (req[k][0] && req[k][1]) ? !m_rr : req[k][1];

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act <= 1'b0; c <= 0; m_rr <= 1'b1; m_rdata <= 8'h00;
                m_init <= 1'b0; m_pend <= INIT_ON;
            end else if (act) begin
                if (m_rd && c == S + T) m_rdata <= din;
                if (c == L) begin
                    act <= 1'b0; c <= 0;
                end else begin
                    c <= c + 1;
                end
            end else if (m_pend) begin
                act <= 1'b1; c <= 1; m_init <= 1'b1; m_rd <= 1'b0;
                m_a <= 2'b11; m_wd <= 8'h80; m_pend <= 1'b0;
            end else if (req[k][0] || req[k][1]) begin
                act <= 1'b1; c <= 1; m_init <= 1'b0; m_who <= w; m_rr <= w;
                m_rd <= rw[k][w]; m_a <= addr[k][w]; m_wd <= wdata[k][w];
            end
        end

        // Observed run lengths and grant order, for the hand-computed checks.
        int         cs_cur = 0, st_cur = 0, lat_cur = 0;
        int         cs_run = 0, st_run = 0, lat = 0;
        logic [7:0] st_dout = 8'h00;
        logic [1:0] st_a = 2'b00;
        int         ack_log[$];

        always @(negedge clk) begin
            cs_cur <= cs_n[k] ? 0 : cs_cur + 1;
            if (cs_n[k] && cs_cur != 0) cs_run <= cs_cur;
            st_cur <= (rd_n[k] && wr_n[k]) ? 0 : st_cur + 1;
            if (rd_n[k] && wr_n[k] && st_cur != 0) st_run <= st_cur;
            if (!wr_n[k]) st_dout <= dout[k];
            if (!(rd_n[k] && wr_n[k])) st_a <= pa[k];
            lat_cur <= (!cs_n[k] && cs_cur == 0) ? 1 : lat_cur + 1;
            if (ack[k][0] || ack[k][1]) lat <= lat_cur + 1;
            if (ack[k][0]) ack_log.push_back(0);
            if (ack[k][1]) ack_log.push_back(1);
            begin
                automatic int ph  = act ? c : 0;
                automatic bit ecs = (ph >= 1) && (ph <= S + T + H);
                automatic bit est = (ph > S) && (ph <= S + T);
                automatic bit eak = (ph == L) && !m_init;
                chk($sformatf("cs_n[%0d]", k), cs_n[k], !ecs);
                chk($sformatf("rd_n[%0d]", k), rd_n[k], !(est && m_rd));
                chk($sformatf("wr_n[%0d]", k), wr_n[k], !(est && !m_rd));
                chk($sformatf("doe[%0d]", k), doe[k], ecs && !m_rd);
                chk($sformatf("busy[%0d]", k), busy[k], act || m_pend);
                chk($sformatf("ack0[%0d]", k), ack[k][0], eak && !m_who);
                chk($sformatf("ack1[%0d]", k), ack[k][1], eak && m_who);
                chk($sformatf("rdata[%0d]", k), rdata[k], m_rdata);
                if (ecs) chk($sformatf("ppi_a[%0d]", k), pa[k], m_a);
                if (ecs && !m_rd) chk($sformatf("dout[%0d]", k), dout[k], m_wd);
            end
        end
    end

    // One bus cycle of requester behaviour: drop on ack, otherwise raise per mode.
    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (req[k][r] && ack[k][r]) begin
                    req[k][r] = 1'b0;
                end else if (!req[k][r] && mode == MHold) begin
                    req[k][r] = 1'b1;
                end else if (!req[k][r] && mode == MRand && $urandom_range(0, 3) == 0) begin
                    rw[k][r]    = 1'($urandom_range(0, 1));
                    addr[k][r]  = 2'($urandom_range(0, 3));
                    wdata[k][r] = 8'($urandom);
                    req[k][r]   = 1'b1;
                end
            end
        end
        if (mode == MRand) din = 8'($urandom);
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) req[k][r] = 1'b0;
        end
    endtask

    function automatic int any_req();
        return int'(req[0][0] | req[0][1] | req[1][0] | req[1][1]);
    endfunction

    task automatic drain(input string nm);
        int n = 0;
        while (any_req() != 0 && n < 200) begin
            cycle();
            n++;
        end
        chk({nm, "_timeout"}, any_req(), 0);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy[0] || busy[1]) && n < 100) begin
            cycle();
            n++;
        end
        chk({nm, "_idle_timeout"}, int'(busy[0] || busy[1]), 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        clear_reqs();
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int b0, b1;
        rst_n = 1'b0;
        din   = 8'h00;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                req[k][r] = 1'b0; rw[k][r] = 1'b0; addr[k][r] = 2'b00; wdata[k][r] = 8'h00;
            end
        end
        repeat (3) cycle();
        for (int k = 0; k < 2; k++) begin
            chk("rst_cs_n", cs_n[k], 1);
            chk("rst_rd_n", rd_n[k], 1);
            chk("rst_wr_n", wr_n[k], 1);
            chk("rst_doe", doe[k], 0);
            chk("rst_rdata", rdata[k], 0);
            chk("rst_busy", busy[k], INIT_ON);
        end
        rst_n = 1'b1;
        wait_idle("init");

        // Write 5A to address 0 from requester 0.
        b0 = g_cfg[0].ack_log.size();
        b1 = g_cfg[1].ack_log.size();
        for (int k = 0; k < 2; k++) begin
            rw[k][0] = 1'b0; addr[k][0] = 2'd0; wdata[k][0] = 8'h5A; req[k][0] = 1'b1;
        end
        drain("wr");
        repeat (2) cycle();
        chk("wr_cs_run0", g_cfg[0].cs_run, 5);
        chk("wr_st_run0", g_cfg[0].st_run, 3);
        chk("wr_lat0", g_cfg[0].lat, 6);
        chk("wr_dout0", g_cfg[0].st_dout, 8'h5A);
        chk("wr_cs_run1", g_cfg[1].cs_run, 9);
        chk("wr_st_run1", g_cfg[1].st_run, 4);
        chk("wr_lat1", g_cfg[1].lat, 10);
        chk("wr_acks0", g_cfg[0].ack_log.size() - b0, 1);
        chk("wr_acks1", g_cfg[1].ack_log.size() - b1, 1);

        // Read from address 2 by requester 1 with C3 on the PPI bus.
        din = 8'hC3;
        for (int k = 0; k < 2; k++) begin
            rw[k][1] = 1'b1; addr[k][1] = 2'd2; req[k][1] = 1'b1;
        end
        drain("rd");
        repeat (2) cycle();
        chk("rd_rdata0", rdata[0], 8'hC3);
        chk("rd_rdata1", rdata[1], 8'hC3);
        chk("rd_a0", g_cfg[0].st_a, 2);
        chk("rd_st_run0", g_cfg[0].st_run, 3);
        chk("rd_lat1", g_cfg[1].lat, 10);
        din = 8'h00;

        // REQ dropped mid-access: ack still pulses once.
        b0 = g_cfg[0].ack_log.size();
        rw[0][0] = 1'b0; addr[0][0] = 2'd1; wdata[0][0] = 8'h11; req[0][0] = 1'b1;
        repeat (3) cycle();
        req[0][0] = 1'b0;
        repeat (12) cycle();
        chk("drop_acks", g_cfg[0].ack_log.size() - b0, 1);

        // Both requesters held from reset: grants alternate 0,1,0,1.
        do_reset();
        b0 = g_cfg[0].ack_log.size();
        b1 = g_cfg[1].ack_log.size();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                rw[k][r] = 1'(r); addr[k][r] = 2'(r + 1); wdata[k][r] = 8'(8'h30 + r);
            end
        end
        mode = MHold;
        n = 0;
        while ((g_cfg[0].ack_log.size() < b0 + 4 || g_cfg[1].ack_log.size() < b1 + 4) && n < 200) begin
            cycle();
            n++;
        end
        mode = MIdle;
        drain("rr");
        chk("rr_timeout", int'(n >= 200), 0);
        if (n < 200) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr_order0_%0d", i), g_cfg[0].ack_log[b0 + i], i % 2);
                chk($sformatf("rr_order1_%0d", i), g_cfg[1].ack_log[b1 + i], i % 2);
            end
        end

        // Reset asserted mid-strobe of a write: pins inactive at once, no ack, idle after.
        wait_idle("pre_arst");
        b0 = g_cfg[0].ack_log.size();
        b1 = g_cfg[1].ack_log.size();
        for (int k = 0; k < 2; k++) begin
            rw[k][0] = 1'b0; addr[k][0] = 2'd0; wdata[k][0] = 8'hA5; req[k][0] = 1'b1;
        end
        n = 0;
        while (wr_n[0] && n < 20) begin
            cycle();
            n++;
        end
        chk("arst_strobe_seen", wr_n[0], 0);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_wr_n", wr_n[k], 1);
            chk("arst_cs_n", cs_n[k], 1);
            chk("arst_doe", doe[k], 0);
            chk("arst_ack0", ack[k][0], 0);
        end
        clear_reqs();
        repeat (2) cycle();
        rst_n = 1'b1;
        wait_idle("arst");
        repeat (3) cycle();
        chk("arst_busy0", busy[0], 0);
        chk("arst_busy1", busy[1], 0);
        chk("arst_noack0", g_cfg[0].ack_log.size() - b0, 0);
        chk("arst_noack1", g_cfg[1].ack_log.size() - b1, 0);

        // Randomized traffic with one reset in the middle.
        mode = MRand;
        repeat (2500) cycle();
        do_reset();
        repeat (2500) cycle();
        mode = MIdle;
        drain("rand");
        repeat (12) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
